// File: rtl/denorm_arbiter_ctrl_pkg.sv
// Shared widths, FSM encoding, source tags and saturation constants for the
// denorm arbiter controller and its shift unit.
package denorm_arbiter_ctrl_pkg;

  localparam int OP_W_DEFAULT    = 40;
  localparam int RES_W_DEFAULT   = 32;
  localparam int FRAC_SH_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic SRC_X = 1'b0;
  localparam logic SRC_Y = 1'b1;

  localparam logic [31:0] SAT_POS = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_NEG = 32'h8000_0000;

endpackage

// File: rtl/denorm_shift_unit.sv
// Combinational denormalizer: 40-bit CORDIC operand to 32-bit result.
// Optional saturation on the type_shift=1 path when DENORM_SAT_EN is defined.
module denorm_shift_unit
  import denorm_arbiter_ctrl_pkg::*;
#(
  parameter int OP_W    = OP_W_DEFAULT,
  parameter int RES_W   = RES_W_DEFAULT,
  parameter int FRAC_SH = FRAC_SH_DEFAULT
) (
  input  logic [OP_W-1:0]  operand_i,
  input  logic             type_shift_i,
  output logic [RES_W-1:0] result_o
`ifdef DENORM_SAT_EN
  ,
  output logic             ovf_o
`endif
);

  logic [RES_W-1:0] trunc;

  always_comb begin
    trunc = type_shift_i ? operand_i[RES_W-1:0] : operand_i[OP_W-1:FRAC_SH];
  end

`ifdef DENORM_SAT_EN
  logic hi_mismatch;

  // Upper bits must be a pure sign extension of the kept MSB, else the value does not fit.
  assign hi_mismatch = operand_i[OP_W-1:RES_W] != {(OP_W-RES_W){operand_i[RES_W-1]}};

  always_comb begin
    ovf_o    = type_shift_i && hi_mismatch;
    result_o = trunc;
    if (ovf_o) begin
      result_o = operand_i[OP_W-1] ? SAT_NEG : SAT_POS;
    end
  end
`else
  assign result_o = trunc;
`endif

endmodule

// File: rtl/denorm_arbiter_ctrl.sv
// Round-robin share of one denorm unit between CORDIC X and Y channels.
// Build option DENORM_SAT_EN adds saturation and the out_ovf port.
module denorm_arbiter_ctrl
  import denorm_arbiter_ctrl_pkg::*;
#(
  parameter int OP_W    = OP_W_DEFAULT,
  parameter int RES_W   = RES_W_DEFAULT,
  parameter int FRAC_SH = FRAC_SH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x_valid,
  output logic             x_ready,
  input  logic [OP_W-1:0]  x_operand,
  input  logic             x_type_shift,
  input  logic             y_valid,
  output logic             y_ready,
  input  logic [OP_W-1:0]  y_operand,
  input  logic             y_type_shift,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_data,
  output logic             out_src,
`ifdef DENORM_SAT_EN
  output logic             out_ovf,
`endif
  output logic [1:0]       dbg_state
);

  // Handshake: every port transfers on a rising edge where valid && ready;
  // a requester holds valid and data stable until it sees ready.

  state_t            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              type_q, type_d;
  logic              src_q, src_d;
  logic              last_grant_q, last_grant_d;
  logic [RES_W-1:0]  out_data_q, out_data_d;
  logic              out_src_q, out_src_d;
  logic              out_valid_q, out_valid_d;
  logic              grant_x, grant_y;
  logic [RES_W-1:0]  unit_result;
`ifdef DENORM_SAT_EN
  logic              unit_ovf;
  logic              ovf_q, ovf_d;
`endif

  denorm_shift_unit #(
    .OP_W    (OP_W),
    .RES_W   (RES_W),
    .FRAC_SH (FRAC_SH)
  ) u_shift (
    .operand_i    (op_q),
    .type_shift_i (type_q),
    .result_o     (unit_result)
`ifdef DENORM_SAT_EN
    ,
    .ovf_o        (unit_ovf)
`endif
  );

  // On a tie the channel that did not win last time is granted.
  always_comb begin
    grant_x = (state_q == ST_IDLE) && x_valid && (!y_valid || last_grant_q == SRC_Y);
    grant_y = (state_q == ST_IDLE) && y_valid && (!x_valid || last_grant_q == SRC_X);
  end

  assign x_ready   = grant_x;
  assign y_ready   = grant_y;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign dbg_state = state_q;
`ifdef DENORM_SAT_EN
  assign out_ovf   = ovf_q;
`endif

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    type_d       = type_q;
    src_d        = src_q;
    last_grant_d = last_grant_q;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    out_valid_d  = out_valid_q;
`ifdef DENORM_SAT_EN
    ovf_d        = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (grant_x) begin
          op_d         = x_operand;
          type_d       = x_type_shift;
          src_d        = SRC_X;
          last_grant_d = SRC_X;
          state_d      = ST_CALC;
        end else if (grant_y) begin
          op_d         = y_operand;
          type_d       = y_type_shift;
          src_d        = SRC_Y;
          last_grant_d = SRC_Y;
          state_d      = ST_CALC;
        end
      end
      ST_CALC: begin
        out_data_d  = unit_result;
        out_src_d   = src_q;
        out_valid_d = 1'b1;
`ifdef DENORM_SAT_EN
        ovf_d       = unit_ovf;
`endif
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      op_q         <= '0;
      type_q       <= 1'b0;
      src_q        <= SRC_X;
      last_grant_q <= SRC_Y;
      out_data_q   <= '0;
      out_src_q    <= 1'b0;
      out_valid_q  <= 1'b0;
`ifdef DENORM_SAT_EN
      ovf_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      type_q       <= type_d;
      src_q        <= src_d;
      last_grant_q <= last_grant_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
      out_valid_q  <= out_valid_d;
`ifdef DENORM_SAT_EN
      ovf_q        <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_denorm_arbiter_ctrl.sv
// Self-checking bench for denorm_arbiter_ctrl: reference model of arbitration
// and denormalization feeding an expected-result queue.
module tb_denorm_arbiter_ctrl;

`ifdef DENORM_SAT_EN
  localparam int W = 34;
`else
  localparam int W = 33;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        x_valid, y_valid, out_ready;
  logic        x_ready, y_ready, out_valid, out_src;
  logic [39:0] x_operand, y_operand;
  logic        x_type_shift, y_type_shift;
  logic [31:0] out_data;
  logic [1:0]  dbg_state;
`ifdef DENORM_SAT_EN
  logic        out_ovf;
`endif
  logic [W-1:0] dut_word;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];
  logic         src_log[$];
  logic [1:0]   m_state;
  logic         m_lg;
  logic         exp_xr, exp_yr;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  denorm_arbiter_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .x_valid      (x_valid),
    .x_ready      (x_ready),
    .x_operand    (x_operand),
    .x_type_shift (x_type_shift),
    .y_valid      (y_valid),
    .y_ready      (y_ready),
    .y_operand    (y_operand),
    .y_type_shift (y_type_shift),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_src      (out_src),
`ifdef DENORM_SAT_EN
    .out_ovf      (out_ovf),
`endif
    .dbg_state    (dbg_state)
  );

`ifdef DENORM_SAT_EN
  assign dut_word = {out_ovf, out_src, out_data};
`else
  assign dut_word = {out_src, out_data};
`endif

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [39:0] op, input logic ts, input logic src);
    logic [31:0] d;
`ifdef DENORM_SAT_EN
    logic   ovf;
    longint s;
`endif
    d = ts ? op[31:0] : op[39:8];
`ifdef DENORM_SAT_EN
    ovf = 1'b0;
    s   = longint'($signed(op));
    if (ts && s > 64'sd2147483647) begin
      d   = 32'h7FFF_FFFF;
      ovf = 1'b1;
    end else if (ts && s < -64'sd2147483648) begin
      d   = 32'h8000_0000;
      ovf = 1'b1;
    end
    return {ovf, src, d};
`else
    return {src, d};
`endif
  endfunction

  // ---------------- scoreboard / reference model ----------------
  always @(negedge clk) begin
    if (rst) begin
      m_state = 2'd0;
      m_lg    = 1'b1;
      exp_q.delete();
    end else begin
      exp_xr = (m_state == 2'd0) && x_valid && (!y_valid || m_lg);
      exp_yr = (m_state == 2'd0) && y_valid && (!x_valid || !m_lg);
      check("x_ready", x_ready, exp_xr);
      check("y_ready", y_ready, exp_yr);
      check("out_valid", out_valid, m_state == 2'd2);
      case (m_state)
        2'd0: begin
          if (exp_xr) begin
            exp_q.push_back(model(x_operand, x_type_shift, 1'b0));
            m_lg    = 1'b0;
            m_state = 2'd1;
          end else if (exp_yr) begin
            exp_q.push_back(model(y_operand, y_type_shift, 1'b1));
            m_lg    = 1'b1;
            m_state = 2'd1;
          end
        end
        2'd1: m_state = 2'd2;
        default: begin
          if (exp_q.size() == 0) begin
            check("sb_empty", 1, 0);
          end else begin
            check("out_word", dut_word, exp_q[0]);
            if (out_ready) begin
              void'(exp_q.pop_front());
              src_log.push_back(out_src);
              m_state = 2'd0;
            end
          end
        end
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic ch, input logic [39:0] op, input logic ts);
    bit done = 0;
    if (ch) begin y_valid = 1'b1; y_operand = op; y_type_shift = ts; end
    else    begin x_valid = 1'b1; x_operand = op; x_type_shift = ts; end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ((ch && y_ready) || (!ch && x_ready)) begin done = 1; break; end
    end
    if (!done) check("send_timeout", 0, 1);
    @(posedge clk); #1;
    if (ch) y_valid = 1'b0; else x_valid = 1'b0;
  endtask

  task automatic wait_valid();
    bit done = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin done = 1; break; end
    end
    if (!done) check("wait_valid_timeout", 0, 1);
  endtask

  task automatic settle();
    bit done = 0;
    logic xf, yf;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      xf = x_valid && x_ready;
      yf = y_valid && y_ready;
      @(posedge clk); #1;
      if (xf) x_valid = 1'b0;
      if (yf) y_valid = 1'b0;
      if (!x_valid && !y_valid && !out_valid && exp_q.size() == 0 && dbg_state == 2'd0) begin
        done = 1;
        break;
      end
    end
    if (!done) check("settle_timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    check("watchdog", 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0]  exp_src;
    logic [31:0] snap_data;
    logic        snap_src;
    logic [63:0] r64;
    logic        xf, yf;
    bit          got4;

    rst = 1'b1;
    x_valid = 1'b0; y_valid = 1'b0; out_ready = 1'b0;
    x_operand = '0; y_operand = '0; x_type_shift = 1'b0; y_type_shift = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_src", out_src, 0);
    check("rst_state", dbg_state, 0);
    check("rst_readys", {x_ready, y_ready}, 0);
    rst = 1'b0;

    // X alone, truncating shift
    out_ready = 1'b1;
    x_valid = 1'b1; x_operand = 40'h12_3456_7890; x_type_shift = 1'b0;
    #1 check("t1_x_ready", x_ready, 1);
    @(posedge clk); #1;
    x_valid = 1'b0;
    check("t1_ov_edge1", out_valid, 0);
    @(posedge clk); #1;
    check("t1_ov_edge2", out_valid, 1);
    check("t1_data", out_data, 32'h1234_5678);
    check("t1_src", out_src, 0);
    @(posedge clk); #1;
    check("t1_consumed", out_valid, 0);

    // Y alone, low-word select
    y_valid = 1'b1; y_operand = 40'h00_8765_4321; y_type_shift = 1'b1;
    #1 check("t2_y_ready", y_ready, 1);
    @(posedge clk); #1;
    y_valid = 1'b0;
    @(posedge clk); #1;
    check("t2_ov", out_valid, 1);
`ifdef DENORM_SAT_EN
    check("t2_data", out_data, 32'h7FFF_FFFF);
`else
    check("t2_data", out_data, 32'h8765_4321);
`endif
    check("t2_src", out_src, 1);
    settle();

    // Continuous contention alternates X, Y, X, Y
    src_log.delete();
    got4 = 0;
    x_valid = 1'b1; x_operand = 40'hAB_CDEF_0123; x_type_shift = 1'b0;
    y_valid = 1'b1; y_operand = 40'h00_1111_2222; y_type_shift = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (src_log.size() >= 4) begin got4 = 1; break; end
    end
    if (!got4) check("rr_timeout", 0, 1);
    exp_src = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      if (i < src_log.size()) check($sformatf("rr_src%0d", i), src_log[i], exp_src[i]);
    end
    settle();

    // Backpressure in HOLD with both channels requesting
    out_ready = 1'b0;
    send(1'b0, 40'h7F_0000_00FF, 1'b0);
    wait_valid();
    snap_data = out_data;
    snap_src  = out_src;
    x_valid = 1'b1; x_operand = 40'h01_0203_0405; x_type_shift = 1'b0;
    y_valid = 1'b1; y_operand = 40'h00_0000_1234; y_type_shift = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, snap_data);
      check("bp_src", out_src, snap_src);
      check("bp_readys", {x_ready, y_ready}, 0);
    end
    check("bp_data_val", snap_data, 32'h7F00_0000);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ov", out_valid, 0);
    check("bp_release_state", dbg_state, 0);
    settle();

    // Reset in CALC after X won: round-robin pointer must return to X-first
    send(1'b0, 40'h55_5555_5555, 1'b0);
    check("rc_in_calc", dbg_state, 1);
    rst = 1'b1;
    #1;
    check("rc_ov", out_valid, 0);
    check("rc_state", dbg_state, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    x_valid = 1'b1; x_operand = 40'h10_2030_4050; x_type_shift = 1'b0;
    y_valid = 1'b1; y_operand = 40'h00_0000_0001; y_type_shift = 1'b1;
    #1;
    check("rc_tie_x", x_ready, 1);
    check("rc_tie_y", y_ready, 0);
    settle();

    // Reset in HOLD drops out_valid without a clock edge
    out_ready = 1'b0;
    send(1'b1, 40'h00_0000_ABCD, 1'b1);
    wait_valid();
    rst = 1'b1;
    #1;
    check("rh_ov", out_valid, 0);
    check("rh_data", out_data, 0);
    do_reset();
    settle();

`ifdef DENORM_SAT_EN
    out_ready = 1'b0;
    send(1'b0, 40'h01_0000_0000, 1'b1);
    wait_valid();
    check("sat_pos_data", out_data, 32'h7FFF_FFFF);
    check("sat_pos_ovf", out_ovf, 1);
    settle();
    out_ready = 1'b0;
    send(1'b1, 40'hFF_8000_0000, 1'b1);
    wait_valid();
    check("sat_edge_data", out_data, 32'h8000_0000);
    check("sat_edge_ovf", out_ovf, 0);
    settle();
`endif

    // Random traffic with random backpressure
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      xf = x_valid && x_ready;
      yf = y_valid && y_ready;
      @(posedge clk); #1;
      if (!x_valid || xf) begin
        r64 = {$urandom, $urandom};
        x_operand    = r64[39:0];
        x_type_shift = 1'($urandom_range(0, 1));
        x_valid      = 1'($urandom_range(0, 1));
      end
      if (!y_valid || yf) begin
        r64 = {$urandom, $urandom};
        y_operand    = r64[39:0];
        y_type_shift = 1'($urandom_range(0, 1));
        y_valid      = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    settle();

    check("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
